// File: rtl/sram64kb_ctrl_if.sv
// Host request/response port and SRAM pin bundle for sram64kb_ctrl.
// The controller takes the slave view; the host/SRAM side takes the master view.
interface sram64kb_ctrl_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [15:0] REQ_ADDR;
  logic [7:0]  REQ_WDATA;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic        RSP_WRITE;
  logic [7:0]  RSP_RDATA;
  logic [9:0]  MEM_ADDR;
  logic        MEM_CE;
  logic        MEM_WEB;
  logic [63:0] MEM_OEB;
  logic [63:0] MEM_CSB;
  logic [7:0]  MEM_IDATA;
  logic [5:0]  MEM_ODATA_SELECT;
  logic [7:0]  MEM_ODATA;

  modport slave (
    input  REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RSP_READY, MEM_ODATA,
    output REQ_READY, RSP_VALID, RSP_WRITE, RSP_RDATA,
    output MEM_ADDR, MEM_CE, MEM_WEB, MEM_OEB, MEM_CSB, MEM_IDATA, MEM_ODATA_SELECT
  );

  modport master (
    output REQ_VALID, REQ_WRITE, REQ_ADDR, REQ_WDATA, RSP_READY, MEM_ODATA,
    input  REQ_READY, RSP_VALID, RSP_WRITE, RSP_RDATA,
    input  MEM_ADDR, MEM_CE, MEM_WEB, MEM_OEB, MEM_CSB, MEM_IDATA, MEM_ODATA_SELECT
  );
endinterface

// File: rtl/sram64kb_ctrl.sv
// Single-access sequencer for the 64-bank 1024x8 SRAM: setup, strobe for
// STROBE_CYCLES, optional read capture, then a held response to the host.
module sram64kb_ctrl #(
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic           CLK,
  input  logic           RST,
  sram64kb_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [63:0] ALL_ONES    = {64{1'b1}};
  localparam logic [3:0]  STROBE_LOAD = 4'(STROBE_CYCLES - 32'd1);

  // Active-low one-hot for a bank: every bit high except the selected one.
  function automatic logic [63:0] bank_mask_n(input logic [5:0] bank);
    logic [63:0] mask;
    mask       = ALL_ONES;
    mask[bank] = 1'b0;
    return mask;
  endfunction

  state_t      state_q;
  logic        write_q;
  logic [3:0]  cnt_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_write_q;
  logic [7:0]  rsp_rdata_q;
  logic [9:0]  mem_addr_q;
  logic        mem_ce_q;
  logic        mem_web_q;
  logic [63:0] mem_oeb_q;
  logic [63:0] mem_csb_q;
  logic [7:0]  mem_idata_q;
  logic [5:0]  mem_sel_q;

  // Access sequencer; every pin and response field is a flop of this block.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      mem_addr_q  <= 10'd0;
      mem_ce_q    <= 1'b0;
      mem_web_q   <= 1'b1;
      mem_oeb_q   <= ALL_ONES;
      mem_csb_q   <= ALL_ONES;
      mem_idata_q <= 8'h00;
      mem_sel_q   <= 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.REQ_VALID) begin
            req_ready_q <= 1'b0;
            write_q     <= bus.REQ_WRITE;
            mem_addr_q  <= bus.REQ_ADDR[9:0];
            mem_sel_q   <= bus.REQ_ADDR[15:10];
            mem_csb_q   <= bank_mask_n(bus.REQ_ADDR[15:10]);
            mem_ce_q    <= 1'b0;
            if (bus.REQ_WRITE) begin
              mem_web_q   <= 1'b0;
              mem_idata_q <= bus.REQ_WDATA;
              mem_oeb_q   <= ALL_ONES;
            end else begin
              mem_web_q   <= 1'b1;
              mem_oeb_q   <= bank_mask_n(bus.REQ_ADDR[15:10]);
            end
            state_q <= S_SETUP;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SETUP: begin
          mem_ce_q <= 1'b1;
          cnt_q    <= STROBE_LOAD;
          state_q  <= S_STROBE;
        end
        S_STROBE: begin
          if (cnt_q == 4'd0) begin
            mem_ce_q <= 1'b0;
            // Writes skip capture: release the bank and acknowledge at once.
            if (write_q) begin
              mem_csb_q   <= ALL_ONES;
              mem_oeb_q   <= ALL_ONES;
              mem_web_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              rsp_write_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              state_q     <= S_CAPTURE;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_CAPTURE: begin
          rsp_rdata_q <= bus.MEM_ODATA;
          mem_csb_q   <= ALL_ONES;
          mem_oeb_q   <= ALL_ONES;
          mem_web_q   <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_write_q <= 1'b0;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (bus.RSP_READY) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            state_q     <= S_RESP;
          end
        end
        default: begin
          mem_ce_q    <= 1'b0;
          mem_web_q   <= 1'b1;
          mem_oeb_q   <= ALL_ONES;
          mem_csb_q   <= ALL_ONES;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.REQ_READY        = req_ready_q;
  assign bus.RSP_VALID        = rsp_valid_q;
  assign bus.RSP_WRITE        = rsp_write_q;
  assign bus.RSP_RDATA        = rsp_rdata_q;
  assign bus.MEM_ADDR         = mem_addr_q;
  assign bus.MEM_CE           = mem_ce_q;
  assign bus.MEM_WEB          = mem_web_q;
  assign bus.MEM_OEB          = mem_oeb_q;
  assign bus.MEM_CSB          = mem_csb_q;
  assign bus.MEM_IDATA        = mem_idata_q;
  assign bus.MEM_ODATA_SELECT = mem_sel_q;

endmodule

// File: doc/sram64kb_ctrl.md
Name: sram64kb_ctrl

Overview:
- Sequencing controller that sits directly upstream of the 64 KB banked SRAM (64 banks of 1024x8).
- Accepts single-byte read/write requests from a valid/ready host port.
- Decodes the 16-bit byte address into a 10-bit row plus a 6-bit bank, and drives the SRAM's strobe, active-low chip/output enables, write enable and output-select pins through a fixed setup/strobe/capture sequence.
- Returns read data, or a write acknowledge, on a valid/ready response port.

Parameters:
STROBE_CYCLES, 1, number of cycles MEM_CE is held high per access; legal range 1..15.

Ports:
CLK  input  1  clock.
RST  input  1  asynchronous, active-high reset.
REQ_VALID  input  1  host request valid.
REQ_READY  output  1  controller can accept a request; high only in IDLE.
REQ_WRITE  input  1  1 = write, 0 = read.
REQ_ADDR  input  16  byte address; [15:10] = bank, [9:0] = row.
REQ_WDATA  input  8  write data.
RSP_VALID  output  1  response valid.
RSP_READY  input  1  host accepts response.
RSP_WRITE  output  1  response is a write acknowledge.
RSP_RDATA  output  8  read data; holds its previous value on a write acknowledge.
MEM_ADDR  output  10  SRAM row address.
MEM_CE  output  1  SRAM strobe.
MEM_WEB  output  1  write enable, active low.
MEM_OEB  output  64  per-bank output enable, active low.
MEM_CSB  output  64  per-bank chip select, active low.
MEM_IDATA  output  8  SRAM write data.
MEM_ODATA_SELECT  output  6  bank select for the SRAM output mux.
MEM_ODATA  input  8  muxed SRAM read data.

Behaviour:
- Reset, asynchronous and effective immediately, including mid-access:
  - State = IDLE, RSP_VALID = 0, RSP_WRITE = 0, RSP_RDATA = 0.
  - MEM_CE = 0, MEM_WEB = 1, MEM_CSB = all 1, MEM_OEB = all 1.
  - MEM_ADDR = 0, MEM_IDATA = 0, MEM_ODATA_SELECT = 0, strobe counter = 0.
- Every output is driven from a flop; there are no combinational paths from inputs to outputs.
- State machine:
  - IDLE: REQ_READY = 1. When REQ_VALID = 1 at a rising edge, latch address, data and direction, then go to SETUP.
  - SETUP, 1 cycle:
    - MEM_ADDR = REQ_ADDR[9:0] and MEM_ODATA_SELECT = REQ_ADDR[15:10].
    - MEM_CSB[bank] = 0; all other CSB bits stay 1.
    - Write: MEM_WEB = 0 and MEM_IDATA = wdata.
    - Read: MEM_WEB = 1 and MEM_OEB[bank] = 0.
    - MEM_CE = 0. Go to STROBE.
  - STROBE: MEM_CE = 1 for exactly STROBE_CYCLES cycles, counted by a 4-bit down-counter. On expiry, go to CAPTURE if the access is a read, or to RESP if it is a write.
  - CAPTURE, reads only, 1 cycle: MEM_CE = 0, CSB/OEB/SELECT held. At the end of the cycle, MEM_ODATA is registered into RSP_RDATA. Go to RESP.
  - RESP:
    - On entry: MEM_CSB and MEM_OEB return to all 1, MEM_WEB = 1, RSP_VALID = 1, RSP_WRITE = the access direction.
    - Address, select and IDATA keep their last values.
    - While RSP_READY = 0, RSP_VALID and RSP_RDATA are held unchanged.
    - On RSP_VALID & RSP_READY: clear RSP_VALID and go to IDLE.
- Latency from the accept edge to RSP_VALID high, with N = STROBE_CYCLES:
  - Read: 2+N cycles.
  - Write: 1+N cycles.
  - REQ_READY rises the cycle after the response handshake.
- Throughput: one access in flight at a time; a new request is never accepted while RSP_VALID = 1.
- Exactly one bank's CSB is ever low. OEB is never low during a write. WEB is never low during a read.
- Address and data are latched at accept; later changes on REQ_* have no effect.
- MEM_ODATA_SELECT stays equal to the latched bank from SETUP until the next accept.
- No bounds error is possible: all 16 address bits map to storage.

Test Plan:
- Write 0xA5 to 0x0000, then read 0x0000: CSB = all 1 except bit 0; write RSP_VALID at accept+2; read RSP_VALID at accept+3 with RSP_RDATA = 0xA5 and RSP_WRITE = 0.
- Write 0x3C to 0xFFFF, then read it back: MEM_ADDR = 0x3FF, SELECT = 63, only CSB[63] low, OEB all 1 during the write, OEB[63] low during the read; RSP_RDATA = 0x3C.
- Hold RSP_READY = 0 for 3 cycles after a read of 0x1234: RSP_VALID and RSP_RDATA stay stable, REQ_READY stays 0, and REQ_READY = 1 the cycle after the handshake.
- STROBE_CYCLES = 3: MEM_CE high for exactly 3 consecutive cycles; read RSP_VALID at accept+5.
- Assert RST during STROBE of a write: MEM_CE = 0, WEB = 1, CSB/OEB all 1 immediately; no response is issued; a later read of an untouched address returns its prior contents.
- Back-to-back writes to banks 5 and 6 with REQ_VALID held high: the second is accepted only after the first response handshake; MEM_CSB bits 5 and 6 are never low together.
